// File: rtl/temp_pkg.sv
// Shared definitions for the temperature path: frame layout, FSM states and clamp limits.
package temp_pkg;

  localparam int TEMP_W    = 10;
  localparam int FRAME_W   = 16;
  localparam int VALID_BIT = 0;

  // Limits in 0.25 degC units
  localparam logic signed [TEMP_W-1:0] TEMP_MIN = -10'sd160;
  localparam logic signed [TEMP_W-1:0] TEMP_MAX =  10'sd480;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_HOLD,
    ST_PUBLISH,
    ST_WAIT
  } state_t;

  function automatic logic signed [TEMP_W-1:0] clamp_temp(input logic signed [TEMP_W-1:0] t);
    if (t < TEMP_MIN)
      return TEMP_MIN;
    else if (t > TEMP_MAX)
      return TEMP_MAX;
    else
      return t;
  endfunction

endpackage

// File: rtl/temp_sampler_sclk_gen.sv
// Serial clock generator: half-period counter with sclk level, rise strobe and half-period-done strobe.
module sclk_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic toggle_en,
  output logic sclk,
  output logic rise,
  output logic half_done
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CNT_W-1:0] cnt;

  assign half_done = en && (cnt == CNT_W'(CLK_DIV - 1));
  // High on the clk edge where sclk goes low->high, i.e. the sampling edge.
  assign rise      = half_done && toggle_en && !sclk;

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      sclk <= 1'b0;
    end else if (!en) begin
      cnt  <= '0;
      sclk <= 1'b0;
    end else begin
      if (half_done)
        cnt <= '0;
      else
        cnt <= cnt + CNT_W'(1);
      if (half_done && toggle_en)
        sclk <= ~sclk;
    end
  end

endmodule

// File: rtl/temp_sampler.sv
// 3-wire temperature sensor front end: periodic 16-bit frame read, valid-bit check, strobed output.
// Optional TEMP_SAMPLER_CLAMP_EN saturates valid readings to [TEMP_MIN, TEMP_MAX].
module temp_sampler
  import temp_pkg::*;
#(
  parameter int CLK_DIV       = 2,
  parameter int SAMPLE_PERIOD = 100
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic                     sensor_miso,
  output logic                     sensor_sclk,
  output logic                     sensor_cs_n,
  output logic signed [TEMP_W-1:0] tempvalue,
  output logic                     shift_en,
  output logic                     invalid_frame,
  output logic                     busy
);

  localparam int PER_W = $clog2(SAMPLE_PERIOD + 1);

  state_t state, next_state;

  logic               sclk_run;
  logic               sclk_toggle;
  logic               sclk_rise;
  logic               half_done;
  logic [4:0]         half_cnt;
  logic [FRAME_W-1:0] shreg;
  logic [PER_W-1:0]   period_cnt;
  logic               frame_start;
  logic signed [TEMP_W-1:0] frame_temp;
  logic signed [TEMP_W-1:0] load_temp;

  sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk_gen (
    .clk       (clk),
    .rst       (rst),
    .en        (sclk_run),
    .toggle_en (sclk_toggle),
    .sclk      (sensor_sclk),
    .rise      (sclk_rise),
    .half_done (half_done)
  );

  assign frame_temp  = shreg[FRAME_W-1 -: TEMP_W];
  assign frame_start = (next_state == ST_SETUP) && (state != ST_SETUP);

`ifdef TEMP_SAMPLER_CLAMP_EN
  assign load_temp = clamp_temp(frame_temp);
`else
  assign load_temp = frame_temp;
`endif

  always_ff @(posedge clk) begin
    if (rst)
      state <= ST_IDLE;
    else
      state <= next_state;
  end

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    next_state = state;
    unique case (state)
      ST_IDLE:    if (enable) next_state = ST_SETUP;
      ST_SETUP:   if (half_done) next_state = ST_SHIFT;
      ST_SHIFT:   if (half_done && half_cnt == 5'd31) next_state = ST_HOLD;
      ST_HOLD:    if (half_done) next_state = ST_PUBLISH;
      ST_PUBLISH: next_state = enable ? ST_WAIT : ST_IDLE;
      ST_WAIT: begin
        if (!enable)
          next_state = ST_IDLE;
        else if (period_cnt == PER_W'(SAMPLE_PERIOD - 1))
          next_state = ST_SETUP;
      end
      default:    next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    sensor_cs_n = 1'b1;
    busy        = 1'b0;
    sclk_run    = 1'b0;
    sclk_toggle = 1'b0;
    unique case (state)
      ST_SETUP: begin
        sensor_cs_n = 1'b0;
        busy        = 1'b1;
        sclk_run    = 1'b1;
      end
      ST_SHIFT: begin
        sensor_cs_n = 1'b0;
        busy        = 1'b1;
        sclk_run    = 1'b1;
        sclk_toggle = 1'b1;
      end
      ST_HOLD: begin
        busy     = 1'b1;
        sclk_run = 1'b1;
      end
      ST_PUBLISH: busy = 1'b1;
      default: ;
    endcase
  end

  // Results are registered on the HOLD->PUBLISH edge so they are visible during PUBLISH.
  always_ff @(posedge clk) begin
    if (rst) begin
      half_cnt      <= '0;
      shreg         <= '0;
      period_cnt    <= '0;
      tempvalue     <= '0;
      shift_en      <= 1'b0;
      invalid_frame <= 1'b0;
    end else begin
      shift_en      <= 1'b0;
      invalid_frame <= 1'b0;

      // Period is measured from cs_n fall to the next cs_n fall.
      if (frame_start)
        period_cnt <= '0;
      else if (state != ST_IDLE)
        period_cnt <= period_cnt + PER_W'(1);

      if (state != ST_SHIFT)
        half_cnt <= '0;
      else if (half_done)
        half_cnt <= half_cnt + 5'd1;

      if (sclk_rise)
        shreg <= {shreg[FRAME_W-2:0], sensor_miso};

      if (state == ST_HOLD && half_done) begin
        if (shreg[VALID_BIT]) begin
          tempvalue <= load_temp;
          shift_en  <= 1'b1;
        end else begin
          invalid_frame <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_temp_sampler.sv
// Self-checking bench for temp_sampler: behavioural sensor, directed and random frames.
module tb_temp_sampler;

  localparam int D  = 2;
  localparam int SP = 100;

  logic              clk = 1'b0;
  logic              rst;
  logic              enable;
  logic              sensor_miso;
  logic              sensor_sclk;
  logic              sensor_cs_n;
  logic signed [9:0] tempvalue;
  logic              shift_en;
  logic              invalid_frame;
  logic              busy;

  logic [15:0] cur_frame = 16'h0000;
  int          rise_cnt  = 0;
  logic        prev_sclk = 1'b0;
  int          cyc       = 0;
  int          last_fall = -1;
  int          exp_temp  = 0;
  int          n_checks  = 0;
  int          n_pass    = 0;
  int          n_fail    = 0;

  temp_sampler #(.CLK_DIV(D), .SAMPLE_PERIOD(SP)) dut (
    .clk           (clk),
    .rst           (rst),
    .enable        (enable),
    .sensor_miso   (sensor_miso),
    .sensor_sclk   (sensor_sclk),
    .sensor_cs_n   (sensor_cs_n),
    .tempvalue     (tempvalue),
    .shift_en      (shift_en),
    .invalid_frame (invalid_frame),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Sensor: presents the next bit after each sclk rise, restarts while deselected.
  always @(negedge clk) begin
    if (sensor_cs_n) begin
      rise_cnt  <= 0;
      prev_sclk <= 1'b0;
    end else begin
      prev_sclk <= sensor_sclk;
      if (sensor_sclk && !prev_sclk)
        rise_cnt <= rise_cnt + 1;
    end
  end

  assign sensor_miso = (rise_cnt < 16) ? cur_frame[15 - rise_cnt] : 1'b0;

  function automatic int model_temp(input logic [15:0] f);
    int t;
    t = $signed(f[15:6]);
`ifdef TEMP_SAMPLER_CLAMP_EN
    if (t > 480)  t = 480;
    if (t < -160) t = -160;
`endif
    return t;
  endfunction

  task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // Runs one frame from its cs_n fall (or from the current cycle if cs_n is already low).
  task automatic run_frame(input logic [15:0] frame, input int drop_at, input bit check_gap);
    int c, cs_low, rises, sh_cnt, inv_cnt, strobe_cyc, busy_bad, held;
    logic p;
    cur_frame = frame;
    c = 0;
    while (sensor_cs_n !== 1'b0 && c < 400) begin
      @(negedge clk);
      c++;
    end
    check("frame_start_seen", (c < 400), 1);
    if (c >= 400) return;
    if (check_gap && last_fall >= 0)
      check("cs_fall_period", cyc - last_fall, SP);
    last_fall = cyc;
    cs_low = 0; rises = 0; sh_cnt = 0; inv_cnt = 0; strobe_cyc = -1; busy_bad = 0; held = 0;
    p = 1'b0;
    for (int k = 0; k <= 34*D + 2; k++) begin
      if (k == drop_at) enable = 1'b0;
      if (sensor_cs_n === 1'b0) cs_low++;
      if (sensor_sclk === 1'b1 && !p) rises++;
      p = sensor_sclk;
      if (shift_en === 1'b1) begin sh_cnt++; strobe_cyc = k; end
      if (invalid_frame === 1'b1) begin inv_cnt++; strobe_cyc = k; end
      if (busy !== (k <= 34*D)) busy_bad++;
      if (k == 34*D - 1) held = tempvalue;
      @(negedge clk);
    end
    check("cs_low_cycles", cs_low, 33*D);
    check("sclk_pulses", rises, 16);
    check("busy_window_errors", busy_bad, 0);
    check("temp_held_before_publish", held, exp_temp);
    check("strobe_cycle", strobe_cyc, 34*D);
    check("shift_en_count", sh_cnt, frame[0] ? 1 : 0);
    check("invalid_count", inv_cnt, frame[0] ? 0 : 1);
    if (frame[0]) exp_temp = model_temp(frame);
    check("tempvalue", tempvalue, exp_temp);
  endtask

  initial begin
    int c, bad;
    logic [15:0] f;
    rst    = 1'b1;
    enable = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_cs_n", sensor_cs_n, 1);
    check("rst_sclk", sensor_sclk, 0);
    check("rst_tempvalue", tempvalue, 0);
    check("rst_shift_en", shift_en, 0);
    check("rst_invalid", invalid_frame, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("idle_cs_n", sensor_cs_n, 1);

    enable = 1'b1;
    run_frame(16'hFE01, -1, 1'b1);
    run_frame(16'h7FC0, -1, 1'b1);
    run_frame(16'h7FC1, -1, 1'b1);
    run_frame(16'h8001, -1, 1'b1);
    for (int i = 0; i < 6; i++) begin
      f = 16'($urandom);
      run_frame(f, -1, 1'b1);
    end

    // Enable dropped mid-frame: the frame still completes, then stays idle.
    run_frame(16'($urandom) | 16'h0001, 20, 1'b1);
    bad = 0;
    for (int k = 0; k < 150; k++) begin
      if (sensor_cs_n !== 1'b1 || busy !== 1'b0) bad++;
      @(negedge clk);
    end
    check("idle_after_drop", bad, 0);

    // Reset mid-frame aborts immediately; a new frame starts right after release.
    cur_frame = 16'h1235;
    enable = 1'b1;
    c = 0;
    while (sensor_cs_n !== 1'b0 && c < 400) begin
      @(negedge clk);
      c++;
    end
    check("reset_frame_start_seen", (c < 400), 1);
    repeat (30) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_cs_n", sensor_cs_n, 1);
    check("abort_sclk", sensor_sclk, 0);
    check("abort_tempvalue", tempvalue, 0);
    check("abort_busy", busy, 0);
    check("abort_strobes", shift_en | invalid_frame, 0);
    rst = 1'b0;
    exp_temp = 0;
    @(negedge clk);
    check("restart_cs_n", sensor_cs_n, 0);
    run_frame(16'($urandom), -1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
